// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Provides the FSM state enum and the step-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step counter width; never narrower than one bit.
    function automatic int cnt_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// Ports: r (partial remainder), bit_in (next dividend bit), divisor -> r_next, q_bit.
module div_step #(
    parameter int SIZE = 4
) (
    input  logic [SIZE:0]   r,
    input  logic            bit_in,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE:0]   r_next,
    output logic            q_bit
);

    logic [SIZE:0] shifted;
    logic [SIZE:0] trial;

    assign shifted = {r[SIZE-1:0], bit_in};
    assign trial   = shifted - {1'b0, divisor};
    // R < divisor keeps the difference inside S+1 signed bits,
    // so the MSB alone tells whether the subtraction went negative.
    assign q_bit   = ~trial[SIZE];
    assign r_next  = q_bit ? trial : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2*SIZE-bit dividend / SIZE-bit divisor, one bit per clock.
// Ports: clk, rst_n, in_valid/in_ready + dividend/divisor, out_valid/out_ready +
//   quotient/remainder/ovf/dz. Macro DIV_ONE_BYPASS_EN: divisor==1 skips the BUSY phase.
module seq_divider
    import div_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SIZE-1:0] dividend,
    input  logic [SIZE-1:0]   divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   quotient,
    output logic [SIZE-1:0]   remainder,
    output logic              ovf,
    output logic              dz
);

    localparam int CW = cnt_w(SIZE);

    div_state_t      state;
    div_state_t      state_n;
    logic [SIZE:0]   r;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] dvsr;
    logic [CW-1:0]   cnt;

    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;
    logic            accept;
    logic            ovf_in;
    logic            byp;
    logic            last;
    logic [SIZE:0]   r_next;
    logic            q_bit;
    logic [SIZE:0]   q_ext;

    assign hi       = dividend[2*SIZE-1:SIZE];
    assign lo       = dividend[SIZE-1:0];
    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign ovf_in   = (hi >= divisor);
    assign last     = (cnt == CW'(SIZE - 1));
    assign q_ext    = {q, q_bit};

`ifdef DIV_ONE_BYPASS_EN
    assign byp = (divisor == SIZE'(1));
`else
    assign byp = 1'b0;
`endif

    div_step #(
        .SIZE(SIZE)
    ) u_step (
        .r      (r),
        .bit_in (q[SIZE-1]),
        .divisor(dvsr),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (ovf_in || byp) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            q         <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else if (accept) begin
            r    <= {1'b0, hi};
            q    <= lo;
            dvsr <= divisor;
            cnt  <= '0;
            if (ovf_in) begin
                quotient  <= '1;
                remainder <= '0;
                ovf       <= 1'b1;
                dz        <= (divisor == '0);
            end else if (byp) begin
                quotient  <= lo;
                remainder <= '0;
                ovf       <= 1'b0;
                dz        <= 1'b0;
            end
        end else if (state == BUSY) begin
            r   <= r_next;
            q   <= q_ext[SIZE-1:0];
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) begin
                quotient  <= q_ext[SIZE-1:0];
                remainder <= r_next[SIZE-1:0];
                ovf       <= 1'b0;
                dz        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (SIZE=4): directed cases plus a full operand sweep.
// Aware of DIV_ONE_BYPASS_EN for the expected latency of divisor==1.
module tb_seq_divider;

    localparam int SIZE = 4;

    typedef struct packed {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dz;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       ovf;
    logic       dz;

    int   total;
    int   bad;
    exp_t sb[$];

    seq_divider #(
        .SIZE(SIZE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .ovf      (ovf),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        e.dvd = a;
        e.dvs = b;
        if (a[7:4] >= b) begin
            e.q   = 4'hF;
            e.r   = 4'h0;
            e.ovf = 1'b1;
            e.dz  = (b == 4'd0);
            e.lat = 1;
        end else begin
            e.q   = 4'(a / b);
            e.r   = 4'(a % b);
            e.ovf = 1'b0;
            e.dz  = 1'b0;
            e.lat = SIZE + 1;
`ifdef DIV_ONE_BYPASS_EN
            if (b == 4'd1) e.lat = 1;
`endif
        end
        return e;
    endfunction

    // Called just after the accepting edge; waits for the result,
    // holds out_ready low for 'hold' cycles, then hands off.
    task automatic collect(input int hold);
        int   n;
        exp_t e;
        n = 1;
        while (!out_valid && n < 20) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("latency", n, e.lat);
        for (int i = 0; i <= hold; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("ovf", ovf, e.ovf);
            chk("dz", dz, e.dz);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        if (!e.ovf) begin
            chk("invariant", 32'(quotient) * 32'(e.dvs) + 32'(remainder),
                32'(e.dvd));
            chk("rem_lt_div", remainder < e.dvs, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_out_valid", out_valid, 0);
        chk("handoff_in_ready", in_ready, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        sb.push_back(model(a, b));
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(hold);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dz", dz, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'd100, 4'd7, 0);
        chk("q_100_7", quotient, 14);
        chk("r_100_7", remainder, 2);
        run_op(8'd200, 4'd5, 0);
        run_op(8'd37, 4'd0, 0);
        run_op(8'd15, 4'd1, 1);

        // Result held for 10 cycles with a second request pending.
        sb.push_back(model(8'd100, 4'd7));
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd7;
        @(posedge clk); #1;
        dividend = 8'd63;
        divisor  = 4'd9;
        collect(10);
        sb.push_back(model(8'd63, 4'd9));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("second_accepted", in_ready, 0);
        collect(0);

        // Reset in the second BUSY cycle aborts the operation.
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_quotient", quotient, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("abort_no_result", out_valid, 0);
        end
        run_op(8'd63, 4'd9, 0);
        chk("q_63_9", quotient, 7);
        chk("r_63_9", remainder, 0);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(8'(a), 4'(b), int'($urandom_range(0, 2)));
            end
        end

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider; the inverse of the array multiplier.
- Takes a 2*SIZE-bit product-width dividend and a SIZE-bit divisor; returns a SIZE-bit quotient and a SIZE-bit remainder.
- Produces one quotient bit per clock.
- Sits downstream of datapath blocks that produce multiplier-width results; valid/ready on both sides.

Parameters:
- SIZE, 4, operand width; dividend is 2*SIZE bits, quotient and remainder are SIZE bits each.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept an operation
- dividend  input  2*SIZE  numerator p
- divisor  input  SIZE  denominator x
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- quotient  output  SIZE  p / x
- remainder  output  SIZE  p % x
- ovf  output  1  quotient does not fit in SIZE bits (includes divide-by-zero)
- dz  output  1  divisor was zero

Behaviour:
- Reset:
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient, remainder, ovf, dz = 0; internal registers cleared.
- Reset asserted mid-operation aborts the operation; no result is produced.
- State machine:
  - IDLE -> BUSY on in_valid&&in_ready when no overflow.
  - IDLE -> DONE on accept with overflow.
  - BUSY -> DONE after exactly SIZE step cycles.
  - DONE -> IDLE on out_ready.
- in_ready=1 only in IDLE.
- On accept, latch the divisor and compute ovf = (dividend[2S-1:S] >= divisor).
  - Since the high half is never negative, a zero divisor always sets ovf.
  - dz = (divisor == 0).
- Overflow path: next cycle DONE with quotient = all ones, remainder = 0, ovf=1, dz as computed. Latency 1.
- Normal path:
  - Partial remainder R (SIZE+1 bits) is initialised to the high half; Q shift register is initialised to the low half.
  - Each BUSY cycle:
    - T = {R[S-1:0], Q[S-1]} - {1'b0, divisor}.
    - If T is non-negative: R=T and shift 1 into Q. Otherwise R={R[S-1:0], Q[S-1]} and shift 0 into Q.
  - Step counter counts 0..SIZE-1 and wraps to 0 on exit.
- Latency: out_valid rises SIZE+1 clock edges after the accepting edge. Result: quotient=Q, remainder=R[S-1:0], ovf=0, dz=0.
- In DONE, outputs are held stable while out_ready=0. out_valid drops the cycle after out_valid&&out_ready.
- No new operation is accepted in the same cycle as result handoff; throughput is one op per SIZE+2 cycles.
- in_valid seen in BUSY or DONE is ignored; the upstream holds it.
- Invariant (ovf=0): quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
- DIV_ONE_BYPASS_EN
- Defined: divisor==1 (never an overflow case) goes IDLE -> DONE directly. quotient = dividend[S-1:0], remainder = 0, latency 1.
- Undefined: divisor 1 takes the normal SIZE-cycle path. Results are identical; only latency differs.

Decomposition:
- Package div_pkg:
  - state enum typedef div_state_t {IDLE, BUSY, DONE}.
  - Function or localparam helper for counter width $clog2(SIZE).
- Sub-module div_step: combinational single restoring step.
  - Inputs: R, incoming bit, divisor.
  - Outputs: next R, quotient bit.
  - Instantiated once, reused each cycle.

Test Plan:
- SIZE=4, dividend=8'd100, divisor=4'd7 -> after 5 edges: quotient=14, remainder=2, ovf=0, dz=0; in_ready=0 during BUSY.
- dividend=8'd200, divisor=4'd5 (high nibble 12>=5) -> 1 cycle later: quotient=4'hF, remainder=0, ovf=1, dz=0.
- dividend=8'd37, divisor=0 -> 1 cycle later: ovf=1, dz=1, quotient=4'hF, remainder=0.
- 100/7 with out_ready held low 10 cycles -> out_valid and outputs stable throughout. A second in_valid in this window is not accepted until 1 cycle after handoff.
- rst_n pulsed low in the 2nd BUSY cycle of 100/7 -> immediate IDLE, out_valid=0, in_ready=1. The next op, 63/9, gives quotient=7, remainder=0.
- Exhaustive SIZE=4 sweep of all dividend/divisor pairs with random out_ready:
  - when ovf=0, check quotient*divisor + remainder == dividend using the multiplier module instance;
  - check ovf against the high-half >= divisor reference;
  - repeat the sweep with DIV_ONE_BYPASS_EN defined.
